// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
//   Sequencer for the HI/LO multiply/divide unit in the EX stage
//   (MULT, MULTU, DIV, DIVU). Runs an iterative radix-2 datapath
//   (shift-add multiply, restoring divide) and stalls IF..EX until the
//   HI/LO result is ready. An exception/ERET flush cancels any operation.
//   HI/LO register writeback happens outside this block.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   start         EX holds a mul/div instruction (stable while stall=1)
//   op[1:0]       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a         rs value (dividend / multiplicand)
//   src_b         rt value (divisor / multiplier)
//   flush         cancels any operation, highest priority
//   stall         freeze IF..EX
//   busy          state != IDLE
//   result_valid  one-cycle pulse, hi_out/lo_out valid for HI/LO write
//   hi_out        product high half / remainder
//   lo_out        product low half / quotient
//
// Configuration
//   MULDIV_FAST_MUL_EN  defined: MULT/MULTU use a single-cycle multiplier
//                       at accept and go straight to DONE.
//                       undefined: multiply iterates WIDTH cycles like divide.
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; accept latches magnitudes, signs and op
// RUN   | one radix-2 iteration per cycle, cnt = 0..WIDTH-1
// DONE  | result_valid pulse; hi_out/lo_out were loaded on entry
// ---------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

    state_t               state;
    logic [5:0]           cnt;
    // Divide: {remainder, quotient}. Multiply: {partial high, multiplier/low}.
    logic [2*WIDTH-1:0]   acc;
    // Divisor magnitude for divide, multiplicand magnitude for multiply.
    logic [WIDTH-1:0]     opnd;
    logic                 sign_a;
    logic                 sign_b;
    logic                 is_div;

    // ---------------- operand decode at accept ----------------
    logic                 op_div;
    logic                 op_signed;
    logic                 neg_a;
    logic                 neg_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 accept;

    assign op_div    = op[1];
    assign op_signed = ~op[0];
    assign neg_a     = op_signed & src_a[WIDTH-1];
    assign neg_b     = op_signed & src_b[WIDTH-1];
    // The most negative value maps to itself, which is its correct
    // unsigned magnitude.
    assign mag_a     = neg_a ? -src_a : src_a;
    assign mag_b     = neg_b ? -src_b : src_b;
    assign accept    = (state == IDLE) & start & ~flush;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0]   fast_prod;
    logic [2*WIDTH-1:0]   ext_a;
    logic [2*WIDTH-1:0]   ext_b;

    // Sign- or zero-extend to 2*WIDTH; the truncated product is then
    // correct for both signed and unsigned operands.
    assign ext_a     = {{WIDTH{neg_a}}, src_a};
    assign ext_b     = {{WIDTH{neg_b}}, src_b};
    assign fast_prod = ext_a * ext_b;
`endif

    // ---------------- one radix-2 iteration ----------------
    logic [WIDTH:0]       rem_sh;
    logic                 rem_ge;
    logic [WIDTH-1:0]     rem_sub;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [2*WIDTH-1:0]   iter_next;

    // Remainder after the left shift needs WIDTH+1 bits to compare
    // against a divisor that may use the full WIDTH.
    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign rem_ge   = rem_sh >= {1'b0, opnd};
    // When rem_ge holds the true difference is below 2^WIDTH, so the
    // low WIDTH bits are exact.
    assign rem_sub  = rem_sh[WIDTH-1:0] - opnd;
    assign div_next = rem_ge ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                             : {acc[2*WIDTH-2:0], 1'b0};

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    assign iter_next = is_div ? div_next : mul_next;

    // ---------------- sign fix on the final iteration ----------------
    logic [WIDTH-1:0]     res_hi;
    logic [WIDTH-1:0]     res_lo;

    always_comb begin
        res_hi = iter_next[2*WIDTH-1:WIDTH];
        res_lo = iter_next[WIDTH-1:0];
        if (is_div) begin
            if (sign_a ^ sign_b) begin
                res_lo = -iter_next[WIDTH-1:0];
            end
            // Remainder follows the dividend's sign.
            if (sign_a) begin
                res_hi = -iter_next[2*WIDTH-1:WIDTH];
            end
        end else if (sign_a ^ sign_b) begin
            {res_hi, res_lo} = -iter_next;
        end
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            is_div <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
        end else if (flush) begin
            // In-flight result is dropped; hi_out/lo_out keep the last one.
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_a <= neg_a;
                        sign_b <= neg_b;
                        is_div <= op_div;
                        cnt    <= '0;
                        if (op_div) begin
                            acc  <= {{WIDTH{1'b0}}, mag_a};
                            opnd <= mag_b;
                            if (src_b == '0) begin
                                hi_out <= src_a;
                                lo_out <= '1;
                                state  <= DONE;
                            end else begin
                                state  <= RUN;
                            end
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            {hi_out, lo_out} <= fast_prod;
                            state            <= DONE;
`else
                            acc   <= {{WIDTH{1'b0}}, mag_b};
                            opnd  <= mag_a;
                            state <= RUN;
`endif
                        end
                    end
                end
                RUN: begin
                    acc <= iter_next;
                    if (cnt == CNT_LAST) begin
                        hi_out <= res_hi;
                        lo_out <= res_lo;
                        cnt    <= '0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                DONE: begin
                    // start seen here is ignored; pipeline re-presents it.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ---------------- outputs ----------------
    // stall must cover the accept cycle itself, so it is decoded from
    // start rather than registered; flush wins over everything.
    assign stall        = ~flush & (((state == IDLE) & start) | (state == RUN));
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE) & ~flush;

endmodule
